// File: rtl/led_frame_serializer.sv
// led_frame_serializer
//   Takes frame bytes over a valid/ready handshake and shifts each frame
//   MSB-first onto a one-bit line for the LED matrix chain, then pulses
//   latch for one cycle once the last bit has gone out.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_i      request a new frame (only looked at in IDLE)
//   din_i        frame byte, bit 7 leaves first
//   din_valid_i  din_i holds a byte
//   din_ready_o  byte is taken this cycle when din_valid_i is also high
//   sdo_o        serial data to the chain (0 whenever sen_o is low)
//   sen_o        sdo_o carries a frame bit; the chain shifts this cycle
//   latch_o      one-cycle pulse after the final bit
//   busy_o       frame in progress (LOAD / SHIFT / LATCH)
//   underrun_o   sticky: the byte source stalled mid-frame
module led_frame_serializer #(
  parameter int FRAME_BITS = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] din_i,
  input  logic       din_valid_i,
  output logic       din_ready_o,
  output logic       sdo_o,
  output logic       sen_o,
  output logic       latch_o,
  output logic       busy_o,
  output logic       underrun_o
);

  localparam int NB  = FRAME_BITS / 8;
  localparam int NBW = $clog2(NB) + 1;
  localparam logic [NBW-1:0] NB_LAST = NBW'(NB - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_e;

  state_e           state_q, state_d;
  logic [7:0]       sr_q, sr_d;
  logic [2:0]       bc_q, bc_d;
  logic [NBW-1:0]   nb_q, nb_d;   // bytes fully shifted out so far
  logic             unr_q, unr_d;

  logic bit0, last_byte, xfer;

  assign bit0      = (bc_q == 3'd0);
  assign last_byte = (nb_q == NB_LAST);
  assign xfer      = din_valid_i && din_ready_o;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bc_q    <= '0;
      nb_q    <= '0;
      unr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bc_q    <= bc_d;
      nb_q    <= nb_d;
      unr_q   <= unr_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bc_d    = bc_q;
    nb_d    = nb_q;
    unr_d   = unr_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
          nb_d    = '0;
          unr_d   = 1'b0;
        end
      end
      LOAD: begin
        if (xfer) begin
          sr_d    = din_i;
          bc_d    = 3'd7;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d = {sr_q[6:0], 1'b0};
        bc_d = bc_q - 3'd1;
        if (bit0) begin
          nb_d = nb_q + NBW'(1);
          if (last_byte) begin
            state_d = LATCH;
          end else if (xfer) begin
            // prefetched byte follows with no gap in the bit stream
            sr_d = din_i;
            bc_d = 3'd7;
          end else begin
            // source not ready: park in LOAD, sen drops, frame resumes later
            state_d = LOAD;
            unr_d   = 1'b1;
          end
        end
      end
      LATCH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs: decoded from registered state only; din_ready also looks at
  // bc/nb so the next byte can be taken in the bit-0 cycle
  always_comb begin
    sen_o       = (state_q == SHIFT);
    sdo_o       = (state_q == SHIFT) && sr_q[7];
    latch_o     = (state_q == LATCH);
    busy_o      = (state_q != IDLE);
    underrun_o  = unr_q;
    din_ready_o = (state_q == LOAD) ||
                  ((state_q == SHIFT) && bit0 && !last_byte);
  end

endmodule

// File: doc/led_frame_serializer.md
# led_frame_serializer

Transmit-side partner of the LED matrix shift chain. It accepts frame data as bytes over a valid/ready handshake and serializes each frame MSB-first onto a one-bit data line, with a per-bit shift enable. After the last bit of a frame it issues a one-cycle latch strobe. It sits between the byte source (host interface or frame buffer) and the serial input of the 256-stage matrix chain.

## Interface
Parameters:
- FRAME_BITS, 256, bits per frame. Must be a multiple of 8 and ≥ 8. Bytes per frame NB = FRAME_BITS/8.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  request a new frame; sampled only in IDLE
- din  in  8  frame byte; bit 7 is shifted first
- din_valid  in  1  din holds a byte
- din_ready  out  1  block accepts din this cycle; transfer occurs when din_valid && din_ready
- sdo  out  1  serial data to chain input
- sen  out  1  sdo is a valid frame bit this cycle; chain shifts on this cycle
- latch  out  1  one-cycle pulse: frame complete, chain contents are valid
- busy  out  1  high from the cycle after an accepted start through the LATCH cycle
- underrun  out  1  sticky: a stall occurred mid-frame; cleared by the next accepted start

## Operation
- Registers:
  - state: IDLE, LOAD, SHIFT, LATCH
  - 8-bit shift register sr
  - 3-bit bit counter bc
  - byte counter nb, width clog2(NB)+1
- IDLE: din_ready=0, sen=0. start=1 → LOAD and nb=0. Clear underrun on the same edge.
- LOAD: din_ready=1.
  - On handshake: sr←din, bc←7, go to SHIFT.
  - Without handshake: stay in LOAD.
- SHIFT: sen=1, sdo=sr[7]. Each cycle sr←sr<<1 and bc decrements.
  - Bit-0 cycle (bc==0): increment nb.
    - If nb+1 == NB, go to LATCH. din_ready=0 in this case.
    - Otherwise din_ready=1 (prefetch). Handshake → load sr←din and bc←7, stay in SHIFT with no gap. No handshake → go to LOAD and set underrun=1.
- LATCH: latch=1, sen=0, din_ready=0. Then go to IDLE.
- sdo=0 whenever sen=0. Outputs are registered from state/sr, so no input-to-output combinational path exists except din_ready's dependence on state/bc/nb.
- start outside IDLE is ignored. It is not queued.
- Stall (LOAD mid-frame) holds sen=0. Downstream must shift only on sen, so frame content is preserved; underrun reports the gap.
- Reset, asserted at any time:
  - state=IDLE, sr=0, bc=0, nb=0.
  - sdo=0, sen=0, latch=0, busy=0, din_ready=0, underrun=0.
  - Any partial frame is discarded and no latch is issued.

## Timing
- Let start be sampled high in IDLE at cycle 0, with din_valid held high.
  - Cycle 1: LOAD. First byte accepted.
  - Cycles 2 .. FRAME_BITS+1: sen=1, one bit per cycle.
  - Cycle FRAME_BITS+2: latch=1.
  - Cycle FRAME_BITS+3: IDLE, busy=0.
- Minimum frame period is FRAME_BITS+3 cycles, when start is reasserted at the first IDLE cycle.
- Byte k (k ≥ 1) is accepted in the bit-0 cycle of byte k-1 when available. Each stall cycle extends the frame by one cycle.
- Last byte: din_ready stays low in its bit-0 cycle. A byte presented then is not consumed and is left for the next frame.
- Reset release: the first cycle after rst_n rises is IDLE. start is honored that same cycle.

## Test plan
- Reset mid-shift:
  - Stimulus: assert rst_n=0 during byte 5 of a frame.
  - Required: all outputs go 0 immediately (asynchronous) and no latch follows. After release, a full frame of 0xA5 repeated produces sdo pattern 1010_0101 ×32 and latch at cycle 258.
- Gapless streaming:
  - Stimulus: bytes 0x00..0x1F with din_valid constantly high.
  - Required: sen high for exactly 256 consecutive cycles, sdo equals the bytes MSB-first, underrun=0, exactly one latch pulse.
- Stall:
  - Stimulus: drop din_valid for 3 cycles before byte 10.
  - Required: sen low for exactly those 3 cycles, bit stream unchanged, underrun=1 at end, latch at cycle 261. Next accepted start clears underrun.
- Ignored start:
  - Stimulus: pulse start during SHIFT and during LATCH.
  - Required: no effect; busy stays 0 after the frame until a fresh start in IDLE.
- Last-byte boundary:
  - Stimulus: hold din_valid high with 0xFF after the 32nd byte.
  - Required: din_ready=0 in the final bit-0 cycle and in LATCH. 0xFF becomes byte 0 of the next frame.
- Loopback:
  - Stimulus: drive the 256-stage chain with sdo, gated by sen.
  - Required: after latch, the chain contents equal the frame written, for a random 32-byte frame.
